// File: rtl/multicycle_control_if.sv
// Control-unit <-> RV32 datapath bundle: instruction/flags in, datapath controls and status out.
interface multicycle_control_if #(
   parameter int unsigned W = 32
);
   logic [31:0]  instruction;
   logic         zero;
   logic         mem_ready;
   logic         branch;
   logic         mem2reg;
   logic         memwrite;
   logic         alusrc;
   logic         regwrite;
   logic [3:0]   aluctl;
   logic         pc_en;
   logic [2:0]   state;
   logic         halted;
   logic [1:0]   err;
   logic [W-1:0] instret;

   modport master (
      input  instruction, zero, mem_ready,
      output branch, mem2reg, memwrite, alusrc, regwrite, aluctl,
             pc_en, state, halted, err, instret
   );

   modport slave (
      output instruction, zero, mem_ready,
      input  branch, mem2reg, memwrite, alusrc, regwrite, aluctl,
             pc_en, state, halted, err, instret
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// ready handshake with timeout, retired-instruction count, halt on illegal opcode.
module multicycle_control #(
   parameter int unsigned W       = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_control_if.master  bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam int unsigned WAIT_W    = 8;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   // Returns {illegal, aluctl} for an instruction word.
   function automatic logic [4:0] decode(input logic [31:0] ir);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [4:0] d;
      op = ir[6:0];
      f3 = ir[14:12];
      f7 = ir[31:25];
      d  = {1'b1, ALU_ADD};
      case (op)
         OP_R: begin
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  d = {1'b0, ALU_ADD};
                  3'b111:  d = {1'b0, ALU_AND};
                  3'b110:  d = {1'b0, ALU_OR};
                  3'b010:  d = {1'b0, ALU_SLT};
                  default: d = {1'b1, ALU_ADD};
               endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               d = {1'b0, ALU_SUB};
            end
         end
         OP_I: begin
            case (f3)
               3'b000:  d = {1'b0, ALU_ADD};
               3'b111:  d = {1'b0, ALU_AND};
               3'b110:  d = {1'b0, ALU_OR};
               3'b010:  d = {1'b0, ALU_SLT};
               default: d = {1'b1, ALU_ADD};
            endcase
         end
         OP_LOAD, OP_STORE, OP_LUI: d = {1'b0, ALU_ADD};
         OP_BEQ:                    d = {1'b0, ALU_SUB};
         default:                   d = {1'b1, ALU_ADD};
      endcase
      return d;
   endfunction

   // Moore control word {branch, mem2reg, memwrite, alusrc, regwrite, aluctl}.
   function automatic logic [8:0] ctl_of(input state_t st, input logic [31:0] ir);
      logic [6:0] op;
      logic       active;
      logic       uses_imm;
      logic [4:0] d;
      op       = ir[6:0];
      d        = decode(ir);
      active   = (st == S_EXEC) || (st == S_MEM) || (st == S_WB);
      uses_imm = (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_LUI);
      return {(st == S_EXEC) && (op == OP_BEQ),
              ((st == S_MEM) || (st == S_WB)) && (op == OP_LOAD),
              (st == S_MEM) && (op == OP_STORE),
              active && uses_imm,
              (st == S_WB),
              active ? d[3:0] : ALU_ADD};
   endfunction

   state_t            r_state;
   logic [31:0]       r_ir;
   logic [WAIT_W-1:0] r_wait;
   logic [1:0]        r_err;
   logic              r_halted;
   logic [8:0]        r_ctl;
   logic              r_pc_en;
   logic [W-1:0]      r_instret;

   state_t            w_nxt_state;
   logic [31:0]       w_nxt_ir;
   logic [WAIT_W-1:0] w_nxt_wait;
   logic [1:0]        w_nxt_err;
   logic              w_illegal;
   logic              w_store_done;
   logic              w_pc_en;
   logic              w_unused_ok;

   assign w_illegal    = decode(r_ir)[4];
   // A store retires in whichever MEM cycle sees mem_ready, so that strobe cannot be pre-registered.
   assign w_store_done = (r_state == S_MEM) && bus.mem_ready && (r_ir[6:0] == OP_STORE);
   assign w_pc_en      = r_pc_en | w_store_done;
   assign w_unused_ok  = &{1'b0, bus.zero, r_ir};

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ir    = r_ir;
      w_nxt_wait  = r_wait;
      w_nxt_err   = r_err;
      case (r_state)
         S_FETCH: begin
            w_nxt_state = S_DECODE;
            w_nxt_ir    = bus.instruction;
         end
         S_DECODE: begin
            if (w_illegal) begin
               w_nxt_state = S_HALT;
               w_nxt_err   = 2'b01;
            end else begin
               w_nxt_state = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_ir[6:0] == OP_LOAD || r_ir[6:0] == OP_STORE) begin
               w_nxt_state = S_MEM;
               w_nxt_wait  = '0;
            end else if (r_ir[6:0] == OP_BEQ) begin
               w_nxt_state = S_FETCH;
            end else begin
               w_nxt_state = S_WB;
            end
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               w_nxt_state = (r_ir[6:0] == OP_LOAD) ? S_WB : S_FETCH;
            end else if (r_wait == WAIT_LAST) begin
               w_nxt_state = S_HALT;
               w_nxt_err   = 2'b10;
            end else begin
               w_nxt_wait = r_wait + WAIT_W'(1);
            end
         end
         S_WB:    w_nxt_state = S_FETCH;
         S_HALT:  w_nxt_state = S_HALT;
         default: w_nxt_state = S_FETCH;
      endcase
   end

   // Outputs are registered by decoding the next state and next IR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_FETCH;
         r_ir      <= '0;
         r_wait    <= '0;
         r_err     <= 2'b00;
         r_halted  <= 1'b0;
         r_ctl     <= {5'b00000, ALU_ADD};
         r_pc_en   <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state  <= w_nxt_state;
         r_ir     <= w_nxt_ir;
         r_wait   <= w_nxt_wait;
         r_err    <= w_nxt_err;
         r_halted <= (w_nxt_state == S_HALT);
         r_ctl    <= ctl_of(w_nxt_state, w_nxt_ir);
         r_pc_en  <= (w_nxt_state == S_WB) ||
                     ((w_nxt_state == S_EXEC) && (w_nxt_ir[6:0] == OP_BEQ));
         if (w_pc_en) begin
            r_instret <= r_instret + W'(1);
         end
      end
   end

   assign bus.branch   = r_ctl[8];
   assign bus.mem2reg  = r_ctl[7];
   assign bus.memwrite = r_ctl[6];
   assign bus.alusrc   = r_ctl[5];
   assign bus.regwrite = r_ctl[4];
   assign bus.aluctl   = r_ctl[3:0];
   assign bus.pc_en    = w_pc_en;
   assign bus.state    = r_state;
   assign bus.halted   = r_halted;
   assign bus.err      = r_err;
   assign bus.instret  = r_instret;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit that sits directly upstream of the RV32 datapath and drives its control inputs. It latches each fetched instruction and sequences it through FETCH/DECODE/EXEC/MEM/WB states. Datapath control signals are decoded from the current state and the latched instruction, and a one-cycle `pc_en` strobe retires each instruction. It handles a ready handshake with data memory (with timeout), counts retired instructions, and halts on illegal opcodes.

## Interface
- `W`, 32: width of the `instret` counter.
- `TIMEOUT`, 16: maximum MEM-state wait cycles before halting with an error; legal range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  instruction word from the datapath instruction memory.
- `zero`  in  1  ALU zero flag from the datapath.
- `mem_ready`  in  1  data memory has completed the current access.
- `branch`, `mem2reg`, `memwrite`, `alusrc`, `regwrite`  out  1 each  datapath controls.
- `aluctl`  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- `pc_en`  out  1  PC update strobe; the datapath only advances the PC when this is high.
- `state`  out  3  state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- `halted`  out  1  the unit is in HALT.
- `err`  out  2  halt cause: 00 none, 01 illegal instruction, 10 memory timeout.
- `instret`  out  W  retired-instruction count.

## Operation
- **Instruction register.** IR captures `instruction` on the clock edge that leaves FETCH. All decoding uses IR, never the live input.
- **Supported classes** (decoded from IR[6:0]):
  - R-type 0110011.
  - I-ALU 0010011.
  - LOAD 0000011.
  - STORE 0100011.
  - BEQ 1100011.
  - LUI 0110111.
  - Every other opcode, including JAL, is illegal.
- **ALU operation decode** (R-type uses funct3 and funct7; I-ALU uses funct3 only):
  - 000 with funct7=0000000 gives ADD; 000 with funct7=0100000 (R-type only) gives SUB.
  - 111 gives AND, 110 gives OR, 010 gives SLT.
  - Any other combination is illegal.
- **State paths per class:**
  - R / I-ALU / LUI: FETCH→DECODE→EXEC→WB→FETCH.
  - LOAD: FETCH→DECODE→EXEC→MEM→WB→FETCH.
  - STORE: FETCH→DECODE→EXEC→MEM→FETCH.
  - BEQ: FETCH→DECODE→EXEC→FETCH.
  - Illegal: DECODE→HALT with `err`=01.
- **Outputs are Moore-decoded** from state and IR. Defaults: all 1-bit controls 0, `aluctl`=0010.
  - `alusrc`=1 in EXEC, MEM and WB for I-ALU, LOAD, STORE and LUI.
  - In EXEC, `aluctl` takes the decoded op; it is ADD for LOAD/STORE and SUB for BEQ.
  - `branch`=1 only in EXEC for BEQ.
  - `mem2reg`=1 in MEM and WB for LOAD.
  - `memwrite`=1 in MEM for STORE.
  - `regwrite`=1 only in WB.
  - `aluctl` holds its EXEC value through MEM and WB.
- **`pc_en`** is high for exactly one cycle, in the final state of each instruction:
  - WB for R, I-ALU, LOAD and LUI.
  - EXEC for BEQ.
  - The exit cycle of MEM for STORE.
  - `instret` increments on every `pc_en` cycle and wraps modulo 2^W.
- **MEM handshake.**
  - MEM is left on the first edge at which `mem_ready`=1. Controls stay constant while waiting.
  - A wait counter is cleared on MEM entry and increments on each MEM cycle with `mem_ready`=0.
  - If the counter reaches TIMEOUT, the next state is HALT with `err`=10 and no `pc_en`.
  - If `mem_ready` and the timeout coincide, `mem_ready` wins.
- **HALT** is absorbing. All controls are 0 and `halted`=1; only reset exits HALT.
- **Reset**, asserted at any time including mid-MEM, takes effect immediately:
  - state=FETCH, IR=0, wait counter=0, `instret`=0, `err`=00, `halted`=0.
  - All controls are 0, `aluctl`=0010, `pc_en`=0.

## Timing
- Cycles per instruction:
  - BEQ: 3.
  - R, I-ALU, LUI: 4.
  - STORE: 4+k.
  - LOAD: 5+k.
  - k = number of MEM cycles with `mem_ready`=0.
- `instret` shows the new value the cycle after `pc_en`.
- `zero` is sampled by the datapath in BEQ EXEC; the controller does not register it.
- After reset deassertion, the first rising edge moves FETCH→DECODE.

## Test plan
- **addi x1,x0,5** (0x00500093) → `state` sequence 0,1,2,4,0. `alusrc`=1 and `aluctl`=0010 in EXEC/WB. `regwrite` and `pc_en` high only in the WB cycle. `instret`=1.
- **sub x3,x1,x2** (0x402081B3) → `aluctl`=0110 and `alusrc`=0 in EXEC. `regwrite` only in WB.
- **beq x1,x2,8 with `zero`=1** (0x00208463) → 3 cycles. `branch`, `pc_en`=1 and `aluctl`=0110 together in EXEC.
- **lw x5,0(x1)** (0x0000A283) with `mem_ready` low for 3 MEM cycles → MEM lasts 4 cycles with `mem2reg`=1 throughout. WB has `regwrite`=`mem2reg`=1. 8 cycles total.
- **sw with `mem_ready` held 0, TIMEOUT=16** → `memwrite` high for 16 cycles. Then `halted`=1, `err`=10, no `pc_en`, and `instret` unchanged.
- **Illegal 0xFFFFFFFF**: → HALT after DECODE, `err`=01.
- **Reset pulse during a LOAD's MEM wait** → state=0, all controls 0 and `instret`=0 immediately, without waiting for a clock edge.
